uart_pix_framer: RTL and testbench
==================================

Name: uart_pix_framer

Overview:
Downstream consumer of the UART byte receiver in the Sobel path. Treats each received byte as one 8-bit grey pixel in raster order and tags it with column/row coordinates and frame markers. Drives the line-buffer/Sobel window stage. Recovers from truncated frames through an inter-byte idle timeout.

Parameters:
IMG_W, 'd100, pixels per line (>=2)
IMG_H, 'd100, lines per frame (>=2)
X_W, 'd10, width of column coordinate; 2**X_W >= IMG_W
Y_W, 'd10, width of row coordinate; 2**Y_W >= IMG_H
TIMEOUT_CYC, 'd5_000_000, idle sys_clk cycles in ACTIVE before abort (100 ms at 50 MHz)
TO_W, 'd23, idle counter width; 2**TO_W > TIMEOUT_CYC

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
pi_data  in  8  received byte, valid when pi_flag=1
pi_flag  in  1  single-cycle byte strobe
po_pix  out  8  pixel value
po_pix_vld  out  1  pixel strobe, one cycle
po_x  out  X_W  column of po_pix, 0..IMG_W-1
po_y  out  Y_W  row of po_pix, 0..IMG_H-1
po_sof  out  1  with po_pix_vld: first pixel of frame (x=0,y=0)
po_eol  out  1  with po_pix_vld: last pixel of line (x=IMG_W-1)
po_eof  out  1  with po_pix_vld: last pixel of frame
po_frame_err  out  1  one-cycle pulse: frame aborted by timeout
po_busy  out  1  high while state is ACTIVE
po_frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0; state IDLE; x_cnt=0, y_cnt=0, idle_cnt=0.
- Latency: pi_flag in cycle N -> po_pix_vld and associated outputs registered in cycle N+1. po_pix/po_x/po_y hold their last value when po_pix_vld=0.
- Back-to-back pi_flag on consecutive cycles is supported; one output pulse per input pulse, no drops.
- FSM, 2 states:
  IDLE: x_cnt=y_cnt=0. pi_flag -> emit pixel (0,0) with po_sof=1, x_cnt<=1, go ACTIVE.
  ACTIVE: pi_flag -> emit pixel (x_cnt,y_cnt).
    x_cnt=IMG_W-1: po_eol=1, x_cnt<=0, y_cnt<=y_cnt+1.
    x_cnt=IMG_W-1 and y_cnt=IMG_H-1: po_eol=1, po_eof=1, po_frame_cnt+1, x_cnt=y_cnt=0, go IDLE.
- Idle timeout (ACTIVE only): idle_cnt clears on pi_flag, else increments. idle_cnt=TIMEOUT_CYC-1 with no pi_flag -> po_frame_err=1 next cycle, counters to 0, go IDLE, po_frame_cnt unchanged. idle_cnt held at 0 in IDLE.
- pi_flag in the terminal idle cycle: the byte wins; pixel accepted, no error.
- po_sof/po_eol/po_eof are 0 whenever po_pix_vld=0.
- po_busy combinational from state (1 in ACTIVE).
- Reset mid-frame: partial frame discarded, no po_eof, no po_frame_err; next byte is (0,0) with po_sof.
- pi_data not sampled when pi_flag=0.

Optional Feature:
Macro PIX_TIMEOUT_EN. Defined: idle timer and po_frame_err as above. Undefined: no idle counter; po_frame_err tied to 0; ACTIVE exits only on end of frame or reset; TIMEOUT_CYC/TO_W unused.

Decomposition:
- Package sobel_pkg: IMG_W/IMG_H defaults, X_W/Y_W, FSM state encoding (ST_IDLE, ST_ACTIVE), TIMEOUT_CYC default.
- One sub-module, pix_idle_timer (clear, enable, expire pulse), instantiated only under PIX_TIMEOUT_EN. Coordinate counters stay inline.

Test Plan:
- IMG_W=4, IMG_H=3; send 12 bytes 0x00..0x0B, 1 cycle gap -> 12 pulses; byte 0: (0,0) sof; bytes 3,7: eol; byte 11: (3,2) eol+eof; po_frame_cnt=1; po_busy low after.
- Same config, 12 bytes on consecutive cycles -> 12 pulses on consecutive cycles, coordinates identical to previous test.
- TIMEOUT_CYC=20; send 5 bytes then idle -> po_frame_err pulse exactly 20 cycles after 5th strobe's cycle (+1 register); po_busy drops; next byte = (0,0) with sof; po_frame_cnt unchanged.
- TIMEOUT_CYC=20; 20-cycle gap with pi_flag on the terminal cycle -> no po_frame_err; pixel (1,0) emitted.
- Assert reset after 6 bytes -> all outputs 0; 12 fresh bytes form a complete frame, eof on 12th.
- Send 256 complete 4x3 frames -> po_frame_cnt wraps to 0; no spurious sof/eof.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel front end.
// Image geometry, coordinate widths, framer FSM states and idle-timeout defaults.
package sobel_pkg;

   localparam int unsigned IMG_W_DEF       = 100;
   localparam int unsigned IMG_H_DEF       = 100;
   localparam int unsigned X_W_DEF         = 10;
   localparam int unsigned Y_W_DEF         = 10;
   localparam int unsigned TIMEOUT_CYC_DEF = 5_000_000;
   localparam int unsigned TO_W_DEF        = 23;
   localparam int unsigned PIX_W           = 8;
   localparam int unsigned FCNT_W          = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } pix_state_e;

   // Frame markers that travel with each pixel strobe
   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pix_tag_t;

endpackage

// File: rtl/pix_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches TIMEOUT_CYC-1 without a clear.
module pix_idle_timer
   import sobel_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned TO_W        = TO_W_DEF
)(
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   logic [TO_W-1:0] cnt_q;

   // A clear in the terminal cycle suppresses the expiry
   assign expire_c = enable && !clear && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
      end else if (clear || expire_c) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + TO_W'(1);
      end
   end

endmodule

// File: rtl/uart_pix_framer.sv
// Tags each received UART byte as a raster-order grey pixel with x/y and frame markers.
// Optional inter-byte idle abort is enabled by defining PIX_TIMEOUT_EN.
module uart_pix_framer
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W       = IMG_W_DEF,
   parameter int unsigned IMG_H       = IMG_H_DEF,
   parameter int unsigned X_W         = X_W_DEF,
   parameter int unsigned Y_W         = Y_W_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int unsigned TO_W        = TO_W_DEF
)(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [PIX_W-1:0]  pi_data,
   input  logic              pi_flag,
   output logic [PIX_W-1:0]  po_pix,
   output logic              po_pix_vld,
   output logic [X_W-1:0]    po_x,
   output logic [Y_W-1:0]    po_y,
   output logic              po_sof,
   output logic              po_eol,
   output logic              po_eof,
   output logic              po_frame_err,
   output logic              po_busy,
   output logic [FCNT_W-1:0] po_frame_cnt
);

   pix_state_e        state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [PIX_W-1:0]  pix_d;
   logic [X_W-1:0]    ox_d;
   logic [Y_W-1:0]    oy_d;
   pix_tag_t          tag_d;
   logic              vld_d;
   logic              err_d;
   logic [FCNT_W-1:0] fcnt_d;
   logic              expire_c;

`ifdef PIX_TIMEOUT_EN
   pix_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_idle_timer (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clear     (pi_flag || (state_q == ST_IDLE)),
      .enable    (state_q == ST_ACTIVE),
      .expire_c  (expire_c)
   );
`else
   logic [TO_W-1:0] unused_cfg;
   assign unused_cfg = TO_W'(TIMEOUT_CYC);
   assign expire_c   = 1'b0;
`endif

   assign po_busy = (state_q == ST_ACTIVE);

   // Next-state, coordinate advance and output payload
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = po_pix;
      ox_d    = po_x;
      oy_d    = po_y;
      tag_d   = '0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      fcnt_d  = po_frame_cnt;
      case (state_q)
         ST_IDLE: begin
            x_d = '0;
            y_d = '0;
            if (pi_flag) begin
               vld_d     = 1'b1;
               pix_d     = pi_data;
               ox_d      = '0;
               oy_d      = '0;
               tag_d.sof = 1'b1;
               x_d       = X_W'(1);
               state_d   = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (pi_flag) begin
               vld_d = 1'b1;
               pix_d = pi_data;
               ox_d  = x_q;
               oy_d  = y_q;
               if (x_q == X_W'(IMG_W - 1)) begin
                  tag_d.eol = 1'b1;
                  x_d       = '0;
                  if (y_q == Y_W'(IMG_H - 1)) begin
                     tag_d.eof = 1'b1;
                     y_d       = '0;
                     fcnt_d    = po_frame_cnt + FCNT_W'(1);
                     state_d   = ST_IDLE;
                  end else begin
                     y_d = y_q + Y_W'(1);
                  end
               end else begin
                  x_d = x_q + X_W'(1);
               end
            end else if (expire_c) begin
               err_d   = 1'b1;
               x_d     = '0;
               y_d     = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         po_pix       <= '0;
         po_pix_vld   <= 1'b0;
         po_x         <= '0;
         po_y         <= '0;
         po_sof       <= 1'b0;
         po_eol       <= 1'b0;
         po_eof       <= 1'b0;
         po_frame_err <= 1'b0;
         po_frame_cnt <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         po_pix       <= pix_d;
         po_pix_vld   <= vld_d;
         po_x         <= ox_d;
         po_y         <= oy_d;
         po_sof       <= tag_d.sof;
         po_eol       <= tag_d.eol;
         po_eof       <= tag_d.eof;
         po_frame_err <= err_d;
         po_frame_cnt <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_uart_pix_framer.sv
// Scoreboard bench for uart_pix_framer on a 4x3 image with a 20-cycle idle timeout.
// Timeout expectations follow PIX_TIMEOUT_EN the same way the design does.
module tb_uart_pix_framer;
   import sobel_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned XW = 2;
   localparam int unsigned YW = 2;
   localparam int unsigned TO = 20;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [7:0]    pi_data;
   logic          pi_flag;
   logic [7:0]    po_pix;
   logic          po_pix_vld;
   logic [XW-1:0] po_x;
   logic [YW-1:0] po_y;
   logic          po_sof, po_eol, po_eof, po_frame_err, po_busy;
   logic [7:0]    po_frame_cnt;

   uart_pix_framer #(
      .IMG_W (W), .IMG_H (H), .X_W (XW), .Y_W (YW), .TIMEOUT_CYC (TO), .TO_W (5)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .pi_data      (pi_data),
      .pi_flag      (pi_flag),
      .po_pix       (po_pix),
      .po_pix_vld   (po_pix_vld),
      .po_x         (po_x),
      .po_y         (po_y),
      .po_sof       (po_sof),
      .po_eol       (po_eol),
      .po_eof       (po_eof),
      .po_frame_err (po_frame_err),
      .po_busy      (po_busy),
      .po_frame_cnt (po_frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [7:0]    pix;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          sof;
      logic          eol;
      logic          eof;
      logic [7:0]    fcnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_fcnt = 8'd0;
   int         n_checks = 0;
   int         n_errors = 0;
   int         err_seen = 0;
   int         run      = 0;
   int         max_run  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pop one expected pixel per output strobe
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (po_frame_err) err_seen++;
         if (po_pix_vld) begin
            exp_t e, a;
            run++;
            if (run > max_run) max_run = run;
            a = '{po_pix, po_x, po_y, po_sof, po_eol, po_eof, po_frame_cnt};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL pixel: unexpected strobe pix=%0h x=%0d y=%0d at %0t",
                        po_pix, po_x, po_y, $time);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  n_errors++;
                  $display("FAIL pixel: got pix=%0h x=%0d y=%0d sof=%0b eol=%0b eof=%0b cnt=%0d expected pix=%0h x=%0d y=%0d sof=%0b eol=%0b eof=%0b cnt=%0d at %0t",
                           a.pix, a.x, a.y, a.sof, a.eol, a.eof, a.fcnt,
                           e.pix, e.x, e.y, e.sof, e.eol, e.eof, e.fcnt, $time);
               end
            end
         end else begin
            run = 0;
            chk("markers_idle", 32'({po_sof, po_eol, po_eof}), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [XW-1:0] x, input logic [YW-1:0] y,
                       input logic sof, input logic eol, input logic eof);
      if (eof) exp_fcnt = exp_fcnt + 8'd1;
      exp_q.push_back('{d, x, y, sof, eol, eof, exp_fcnt});
      pi_data = d;
      pi_flag = 1'b1;
      tick(1);
      pi_flag = 1'b0;
      pi_data = 8'($urandom);
   endtask

   // Byte i of a 4x3 frame: x=i%4, y=i/4, sof at 0, eol at x=3, eof at 11
   task automatic send_idx(input int i, input logic [7:0] d);
      send(d, XW'(i % 4), YW'(i / 4), i == 0, (i % 4) == 3, i == 11);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      pi_flag   = 1'b0;
      #2;
      chk("rst_outputs", 32'({po_pix, po_pix_vld, po_x, po_y, po_sof, po_eol, po_eof,
                               po_frame_err, po_busy, po_frame_cnt}), 32'd0);
      exp_fcnt = 8'd0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      pi_data   = 8'h00;
      pi_flag   = 1'b0;
      sys_rst_n = 1'b0;
      #12;
      do_reset();

      // 1: spaced bytes
      for (int i = 0; i < 12; i++) begin
         send_idx(i, 8'(i));
         tick(1);
      end
      chk("t1_busy", 32'(po_busy), 32'd0);
      chk("t1_fcnt", 32'(po_frame_cnt), 32'd1);

      // 2: back-to-back bytes
      tick(2);
      max_run = 0;
      for (int i = 0; i < 12; i++) send_idx(i, 8'(8'h40 + i));
      tick(2);
      chk("t2_run", 32'(max_run), 32'd12);
      chk("t2_busy", 32'(po_busy), 32'd0);
      chk("t2_fcnt", 32'(po_frame_cnt), 32'd2);

      // 3: truncated frame, idle
      e0 = err_seen;
      for (int i = 0; i < 5; i++) send_idx(i, 8'(8'h80 + i));
      tick(19);
      chk("t3_err_early", 32'(po_frame_err), 32'd0);
      tick(1);
`ifdef PIX_TIMEOUT_EN
      chk("t3_err", 32'(po_frame_err), 32'd1);
      chk("t3_busy", 32'(po_busy), 32'd0);
      tick(1);
      chk("t3_err_pulse", 32'(po_frame_err), 32'd0);
      chk("t3_fcnt", 32'(po_frame_cnt), 32'd2);
      for (int i = 0; i < 12; i++) send_idx(i, 8'(8'h90 + i));
      tick(1);
      chk("t3_err_count", 32'(err_seen - e0), 32'd1);
`else
      chk("t3_err", 32'(po_frame_err), 32'd0);
      chk("t3_busy", 32'(po_busy), 32'd1);
      tick(1);
      for (int i = 5; i < 12; i++) send_idx(i, 8'(8'h90 + i));
      tick(1);
      chk("t3_err_count", 32'(err_seen - e0), 32'd0);
`endif
      chk("t3_fcnt_end", 32'(po_frame_cnt), 32'd3);

      // 4: byte arrives in the terminal idle cycle
      e0 = err_seen;
      send_idx(0, 8'hA0);
      tick(19);
      send_idx(1, 8'hA1);
      tick(3);
      chk("t4_no_err", 32'(err_seen - e0), 32'd0);
      chk("t4_busy", 32'(po_busy), 32'd1);
      for (int i = 2; i < 12; i++) send_idx(i, 8'(8'hA0 + i));
      tick(1);
      chk("t4_fcnt", 32'(po_frame_cnt), 32'd4);

      // 5: reset mid-frame discards partial frame
      e0 = err_seen;
      for (int i = 0; i < 6; i++) send_idx(i, 8'(8'hC0 + i));
      tick(1);
      chk("t5_q_drained", 32'(exp_q.size()), 32'd0);
      do_reset();
      for (int i = 0; i < 12; i++) send_idx(i, 8'(8'hD0 + i));
      tick(1);
      chk("t5_fcnt", 32'(po_frame_cnt), 32'd1);
      chk("t5_no_err", 32'(err_seen - e0), 32'd0);

      // 6: 256 frames wrap the frame counter
      do_reset();
      max_run = 0;
      for (int f = 0; f < 256; f++)
         for (int i = 0; i < 12; i++) send_idx(i, 8'(f + i));
      tick(2);
      chk("t6_run", 32'(max_run), 32'd3072);
      chk("t6_fcnt_wrap", 32'(po_frame_cnt), 32'd0);
      chk("t6_busy", 32'(po_busy), 32'd0);

      tick(3);
      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
